// File: rtl/bmp_binarize_ctrl.sv
// Streams a 24-bit BMP from ROM to RAM: header and trailing bytes are copied unchanged,
// and each B,G,R pixel is replaced by all-ones or zero depending on its gray level.
module bmp_binarize_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned BYTE_WIDTH  = 8,
  parameter int unsigned HEADER_SIZE = 54,
  parameter int unsigned TOTAL_SIZE  = 786486,
  parameter int unsigned THRESHOLD   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ROM_ren,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  input  logic [BYTE_WIDTH-1:0] ROM_out,
  output logic                  RAM_wen,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] RAM_din
);

  typedef enum logic [2:0] {
    StIdle, StHdr, StPixRd, StPixAcc, StPixWr, StTail, StDone
  } state_e;

  // Comparing the 3-byte sum against 3*THRESHOLD avoids dividing by three.
  localparam logic [9:0] WhiteLevel = 10'(3 * THRESHOLD);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              phase_q, phase_d;
  logic [9:0]              sum_q, sum_d;
  logic                    cp_wen_q;
  logic [ADDR_WIDTH-1:0]   cp_addr_q;
  logic [ADDR_WIDTH-1:0]   rom_hold_q, ram_hold_q;

  logic                    rd_en, copy_rd, pix_wen;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [31:0]             addr_inc32;
  logic [BYTE_WIDTH-1:0]   pix_byte;

  // Where to go once the byte block ending just before address n is finished.
  function automatic state_e after_block(input logic [31:0] n);
    if (n + 32'd3 <= TOTAL_SIZE) begin
      return StPixRd;
    end else if (n < TOTAL_SIZE) begin
      return StTail;
    end
    return StDone;
  endfunction

  assign addr_inc32 = 32'(addr_q) + 32'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    sum_d   = sum_q;
    rd_en   = 1'b0;
    copy_rd = 1'b0;
    pix_wen = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHdr;
          addr_d  = '0;
          phase_d = '0;
        end
      end
      StHdr: begin
        rd_en   = 1'b1;
        copy_rd = 1'b1;
        addr_d  = addr_q + 1'b1;
        if (addr_inc32 == HEADER_SIZE) state_d = after_block(addr_inc32);
      end
      StPixRd: begin
        // Read data lags by one cycle, so phase 0 clears and phases 1-2 add B and G.
        rd_en   = 1'b1;
        rd_addr = addr_q + ADDR_WIDTH'(phase_q);
        sum_d   = (phase_q == 2'd0) ? '0 : sum_q + 10'(ROM_out);
        if (phase_q == 2'd2) begin
          phase_d = '0;
          state_d = StPixAcc;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StPixAcc: begin
        sum_d   = sum_q + 10'(ROM_out);
        state_d = StPixWr;
      end
      StPixWr: begin
        pix_wen = 1'b1;
        addr_d  = addr_q + 1'b1;
        if (phase_q == 2'd2) begin
          phase_d = '0;
          state_d = after_block(addr_inc32);
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StTail: begin
        rd_en   = 1'b1;
        copy_rd = 1'b1;
        addr_d  = addr_q + 1'b1;
        if (addr_inc32 == TOTAL_SIZE) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign pix_byte = (sum_q >= WhiteLevel) ? {BYTE_WIDTH{1'b1}} : '0;

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign ROM_ren  = rd_en;
  assign ROM_addr = rd_en ? rd_addr : rom_hold_q;
  // A pending copy write never coincides with a pixel write.
  assign RAM_wen  = cp_wen_q | pix_wen;
  assign RAM_addr = cp_wen_q ? cp_addr_q : (pix_wen ? addr_q : ram_hold_q);
  assign RAM_din  = cp_wen_q ? ROM_out : (pix_wen ? pix_byte : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      phase_q    <= '0;
      sum_q      <= '0;
      cp_wen_q   <= 1'b0;
      cp_addr_q  <= '0;
      rom_hold_q <= '0;
      ram_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      sum_q    <= sum_d;
      cp_wen_q <= copy_rd;
      if (copy_rd) cp_addr_q <= addr_q;
      if (rd_en) rom_hold_q <= rd_addr;
      if (RAM_wen) ram_hold_q <= RAM_addr;
    end
  end

endmodule

// File: tb/tb_bmp_binarize_ctrl.sv
// Self-checking bench: two instances (60-byte image, 59-byte image with a 2-byte tail)
// against a byte-level image model and a write log.
module tb_bmp_binarize_ctrl;

  localparam int HdrSize = 54;
  localparam int TotA    = 60;
  localparam int TotB    = 59;
  localparam int Thr     = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  logic        busy_a, done_a, ren_a, wen_a, busy_b, done_b, ren_b, wen_b;
  logic [19:0] rom_addr_a, ram_addr_a, rom_addr_b, ram_addr_b;
  logic [7:0]  rom_out_a, ram_din_a, rom_out_b, ram_din_b;

  bmp_binarize_ctrl #(
    .ADDR_WIDTH(20), .BYTE_WIDTH(8), .HEADER_SIZE(HdrSize), .TOTAL_SIZE(TotA), .THRESHOLD(Thr)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .ROM_ren(ren_a), .ROM_addr(rom_addr_a), .ROM_out(rom_out_a),
    .RAM_wen(wen_a), .RAM_addr(ram_addr_a), .RAM_din(ram_din_a)
  );

  bmp_binarize_ctrl #(
    .ADDR_WIDTH(20), .BYTE_WIDTH(8), .HEADER_SIZE(HdrSize), .TOTAL_SIZE(TotB), .THRESHOLD(Thr)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .ROM_ren(ren_b), .ROM_addr(rom_addr_b), .ROM_out(rom_out_b),
    .RAM_wen(wen_b), .RAM_addr(ram_addr_b), .RAM_din(ram_din_b)
  );

  logic [7:0] rom_a [64];
  logic [7:0] rom_b [64];

  // ROMs with one cycle read latency
  always @(posedge clk) begin
    if (ren_a) rom_out_a <= rom_a[rom_addr_a[5:0]];
    if (ren_b) rom_out_b <= rom_b[rom_addr_b[5:0]];
  end

  logic [27:0] wlog_a [$];
  logic [27:0] wlog_b [$];
  int done_cnt_a = 0, done_cnt_b = 0, oob_a = 0, oob_b = 0, rst_wr = 0;

  always @(posedge clk) begin
    if (wen_a) wlog_a.push_back({ram_addr_a, ram_din_a});
    if (wen_b) wlog_b.push_back({ram_addr_b, ram_din_b});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if ((ren_a && 32'(rom_addr_a) >= TotA) || (wen_a && 32'(ram_addr_a) >= TotA)) oob_a++;
    if ((ren_b && 32'(rom_addr_b) >= TotB) || (wen_b && 32'(ram_addr_b) >= TotB)) oob_b++;
    if (rst && (wen_a || wen_b)) rst_wr++;
  end

  int total = 0, bad = 0;
  logic [7:0] exp_img [64];
  int exp_done;

  function automatic logic [7:0] rom_byte(input bit sel, input int i);
    return sel ? rom_b[i] : rom_a[i];
  endfunction

  // Reference image and done cycle (the cycle with start high is cycle 1).
  task automatic build_expected(input bit sel);
    int tot = sel ? TotB : TotA;
    int p = HdrSize, npix = 0, ntail = 0, s;
    for (int i = 0; i < HdrSize; i++) exp_img[i] = rom_byte(sel, i);
    while (p + 3 <= tot) begin
      s = int'(rom_byte(sel, p)) + int'(rom_byte(sel, p + 1)) + int'(rom_byte(sel, p + 2));
      for (int k = 0; k < 3; k++) exp_img[p + k] = (s >= 3 * Thr) ? 8'hFF : 8'h00;
      p += 3;
      npix++;
    end
    while (p < tot) begin
      exp_img[p] = rom_byte(sel, p);
      p++;
      ntail++;
    end
    exp_done = 2 + HdrSize + 7 * npix + ntail;
  endtask

  // Number of deviations of the write log (from entry 'from') from one in-order pass.
  function automatic int seq_errs(input bit sel, input int from);
    int tot = sel ? TotB : TotA;
    int cnt = (sel ? wlog_b.size() : wlog_a.size()) - from;
    int n = (cnt != tot) ? 1 : 0;
    logic [27:0] e;
    for (int k = 0; k < tot && k < cnt; k++) begin
      e = sel ? wlog_b[from + k] : wlog_a[from + k];
      if (int'(e[27:8]) != k || e[7:0] !== exp_img[k]) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] logged(input bit sel, input int from, input int addr);
    logic [7:0] v = 8'hxx;
    int n = sel ? wlog_b.size() : wlog_a.size();
    logic [27:0] e;
    for (int k = from; k < n; k++) begin
      e = sel ? wlog_b[k] : wlog_a[k];
      if (int'(e[27:8]) == addr) v = e[7:0];
    end
    return v;
  endfunction

  task automatic fill_rom(input bit sel);
    for (int i = 0; i < 64; i++) begin
      if (sel) rom_b[i] = 8'($urandom);
      else rom_a[i] = 8'($urandom);
    end
  endtask

  task automatic set_px(input bit sel, input int p, input logic [7:0] b, g, r);
    if (sel) begin
      rom_b[p] = b; rom_b[p + 1] = g; rom_b[p + 2] = r;
    end else begin
      rom_a[p] = b; rom_a[p + 1] = g; rom_a[p + 2] = r;
    end
  endtask

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  // Runs one conversion; extra start pulses at cycles x1/x2 (0 = none).
  task automatic run_conv(input bit sel, input int x1, input int x2,
                          output int done_cyc, output int busy_bad, output int hold_bad);
    int cyc;
    done_cyc = -1;
    busy_bad = 0;
    hold_bad = 0;
    @(posedge clk); #1;
    drive_start(sel, 1'b1);
    cyc = 1;
    while (cyc < 300 && done_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      drive_start(sel, cyc == x1 || cyc == x2);
      if ((sel ? busy_b : busy_a) !== (cyc < exp_done)) busy_bad++;
      // second read cycle of the first pixel: last header write address is held
      if (cyc == HdrSize + 3 && ((sel ? wen_b : wen_a) !== 1'b0 ||
          32'(sel ? ram_addr_b : ram_addr_a) != HdrSize - 1)) hold_bad++;
      // accumulate cycle: no read, last read address (B,G,R of first pixel) held
      if (cyc == HdrSize + 5 && ((sel ? ren_b : ren_a) !== 1'b0 ||
          32'(sel ? rom_addr_b : rom_addr_a) != HdrSize + 2)) hold_bad++;
      if ((sel ? done_b : done_a) === 1'b1) done_cyc = cyc;
    end
    drive_start(sel, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    start_a = 1'b1;  // coincident with reset, must be ignored
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy_a, done_a, ren_a, wen_a, rom_addr_a, ram_addr_a, ram_din_a} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_a got=%h want=0",
               {busy_a, done_a, ren_a, wen_a, rom_addr_a, ram_addr_a, ram_din_a});
    end
    total++;
    if ({busy_b, done_b, ren_b, wen_b, rom_addr_b, ram_addr_b, ram_din_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_b got=%h want=0",
               {busy_b, done_b, ren_b, wen_b, rom_addr_b, ram_addr_b, ram_din_b});
    end
    start_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy_a !== 1'b0 || wlog_a.size() != 0) begin
      bad++;
      $display("FAIL start_in_reset got busy=%b writes=%0d want busy=0 writes=0",
               busy_a, wlog_a.size());
    end
  endtask

  task automatic test_basic;
    int l0 = wlog_a.size(), d0 = done_cnt_a, dc, bb, hb;
    fill_rom(0);
    set_px(0, 54, 8'd100, 8'd100, 8'd100);
    set_px(0, 57, 8'd10, 8'd20, 8'd30);
    build_expected(0);
    run_conv(0, 0, 0, dc, bb, hb);
    total++;
    if (dc != 1 + 55 + 14) begin
      bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", dc, 1 + 55 + 14);
    end
    total++;
    if (seq_errs(0, l0) != 0) begin
      bad++; $display("FAIL basic_write_seq got=%0d errors want=0", seq_errs(0, l0));
    end
    total++;
    if (logged(0, l0, 55) !== 8'h00 || logged(0, l0, 59) !== 8'h00) begin
      bad++; $display("FAIL basic_pixels got=%h/%h want=00/00", logged(0, l0, 55), logged(0, l0, 59));
    end
    total++;
    if (done_cnt_a - d0 != 1 || oob_a != 0) begin
      bad++; $display("FAIL basic_done_oob got=%0d/%0d want=1/0", done_cnt_a - d0, oob_a);
    end
    total++;
    if (bb != 0) begin
      bad++; $display("FAIL basic_busy got=%0d bad cycles want=0", bb);
    end
    total++;
    if (hb != 0) begin
      bad++; $display("FAIL basic_addr_hold got=%0d want=0", hb);
    end
  endtask

  task automatic test_threshold;
    int l0 = wlog_a.size(), dc, bb, hb;
    fill_rom(0);
    set_px(0, 54, 8'd128, 8'd128, 8'd128);
    set_px(0, 57, 8'd127, 8'd128, 8'd128);
    build_expected(0);
    run_conv(0, 0, 0, dc, bb, hb);
    total++;
    if (seq_errs(0, l0) != 0) begin
      bad++; $display("FAIL thr_write_seq got=%0d errors want=0", seq_errs(0, l0));
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (logged(0, l0, 54 + k) !== 8'hFF || logged(0, l0, 57 + k) !== 8'h00) begin
        bad++;
        $display("FAIL thr_byte%0d got=%h/%h want=ff/00", k, logged(0, l0, 54 + k),
                 logged(0, l0, 57 + k));
      end
    end
  endtask

  task automatic test_saturate;
    int l0 = wlog_a.size(), dc, bb, hb;
    fill_rom(0);
    set_px(0, 54, 8'd255, 8'd255, 8'd255);
    build_expected(0);
    run_conv(0, 0, 0, dc, bb, hb);
    total++;
    if (logged(0, l0, 54) !== 8'hFF || logged(0, l0, 55) !== 8'hFF || logged(0, l0, 56) !== 8'hFF)
    begin
      bad++;
      $display("FAIL sat_pixel got=%h%h%h want=ffffff", logged(0, l0, 54), logged(0, l0, 55),
               logged(0, l0, 56));
    end
    total++;
    if (seq_errs(0, l0) != 0) begin
      bad++; $display("FAIL sat_write_seq got=%0d errors want=0", seq_errs(0, l0));
    end
  endtask

  task automatic test_random;
    int l0, dc, bb, hb;
    for (int it = 0; it < 4; it++) begin
      l0 = wlog_a.size();
      fill_rom(0);
      for (int p = 54; p < 60; p += 3)
        set_px(0, p, 8'($urandom_range(100, 160)), 8'($urandom_range(100, 160)),
               8'($urandom_range(100, 160)));
      build_expected(0);
      run_conv(0, 0, 0, dc, bb, hb);
      total++;
      if (seq_errs(0, l0) != 0 || dc != exp_done) begin
        bad++;
        $display("FAIL rand%0d got=%0d errors done=%0d want=0 errors done=%0d", it,
                 seq_errs(0, l0), dc, exp_done);
      end
    end
  endtask

  task automatic test_tail;
    int l0 = wlog_b.size(), d0 = done_cnt_b, dc, bb, hb;
    fill_rom(1);
    set_px(1, 54, 8'd200, 8'd200, 8'd10);
    rom_b[57] = 8'hAB;
    rom_b[58] = 8'hCD;
    build_expected(1);
    run_conv(1, 0, 0, dc, bb, hb);
    total++;
    if (logged(1, l0, 57) !== 8'hAB || logged(1, l0, 58) !== 8'hCD) begin
      bad++; $display("FAIL tail_bytes got=%h/%h want=ab/cd", logged(1, l0, 57), logged(1, l0, 58));
    end
    total++;
    if (logged(1, l0, 54) !== 8'hFF) begin
      bad++; $display("FAIL tail_pixel got=%h want=ff", logged(1, l0, 54));
    end
    total++;
    if (oob_b != 0) begin
      bad++; $display("FAIL tail_no_access_59 got=%0d want=0", oob_b);
    end
    total++;
    if (dc != 65 || done_cnt_b - d0 != 1) begin
      bad++; $display("FAIL tail_done got=%0d/%0d want=65/1", dc, done_cnt_b - d0);
    end
    total++;
    if (seq_errs(1, l0) != 0 || bb != 0) begin
      bad++; $display("FAIL tail_seq_busy got=%0d/%0d want=0/0", seq_errs(1, l0), bb);
    end
  endtask

  task automatic test_back_to_back;
    int l0 = wlog_a.size(), d0 = done_cnt_a, dc, bb, hb;
    fill_rom(0);
    build_expected(0);
    run_conv(0, 10, 60, dc, bb, hb);
    total++;
    if (seq_errs(0, l0) != 0) begin
      bad++; $display("FAIL b2b_write_seq got=%0d errors want=0", seq_errs(0, l0));
    end
    total++;
    if (done_cnt_a - d0 != 1 || dc != exp_done) begin
      bad++; $display("FAIL b2b_done got=%0d pulses cyc=%0d want=1 cyc=%0d", done_cnt_a - d0, dc,
                      exp_done);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_after got=%b want=0", busy_a);
    end
  endtask

  task automatic test_abort;
    int l0, l1, dc, bb, hb;
    fill_rom(0);
    set_px(0, 54, 8'd250, 8'd240, 8'd230);
    build_expected(0);
    @(posedge clk); #1;
    start_a = 1'b1;
    for (int k = 0; k < 61; k++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    total++;
    if (wen_a !== 1'b1 || ram_addr_a !== 20'd56 || ram_din_a !== exp_img[56]) begin
      bad++;
      $display("FAIL abort_third_wr got=%b/%0d/%h want=1/56/%h", wen_a, ram_addr_a, ram_din_a,
               exp_img[56]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy_a, done_a, ren_a, wen_a, rom_addr_a, ram_addr_a, ram_din_a} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0",
               {busy_a, done_a, ren_a, wen_a, rom_addr_a, ram_addr_a, ram_din_a});
    end
    l0 = wlog_a.size();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wlog_a.size() != l0 || rst_wr != 0) begin
      bad++; $display("FAIL abort_no_writes got=%0d/%0d want=0/0", wlog_a.size() - l0, rst_wr);
    end
    l1 = wlog_a.size();
    run_conv(0, 0, 0, dc, bb, hb);
    total++;
    if (seq_errs(0, l1) != 0) begin
      bad++; $display("FAIL abort_restart_seq got=%0d errors want=0", seq_errs(0, l1));
    end
    total++;
    if (dc != exp_done) begin
      bad++; $display("FAIL abort_restart_done got=%0d want=%0d", dc, exp_done);
    end
  endtask

  initial begin
    fill_rom(0);
    fill_rom(1);
    test_reset();
    test_basic();
    test_threshold();
    test_saturate();
    test_random();
    test_tail();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
